ttc_tx_encoder: RTL and testbench

Transmit-side encoder for the TTC serial link. Accepts 16-bit words through a valid/ready handshake and buffers them in a small FIFO. Wraps each word in a 20-bit frame (4-bit header, 16-bit payload) and emits the frame 2 bits per clk160 cycle, giving 320 Mb/s, to an external output serializer. Between data words, and during a start-up sync burst, it sends idle frames rich in transitions so the receiving decoder can lock phase and word alignment.

---
 rtl/ttc_pkg.sv | 19 +
 rtl/ttc_tx_encoder_fifo.sv | 60 ++++++
 rtl/ttc_tx_encoder.sv | 129 ++++++++++++
 tb/tb_ttc_tx_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared TTC link constants, default frame headers and framing FSM state type.
// Used by both the transmit encoder and the receive decoder.
package ttc_pkg;

    localparam int FRAME_BITS      = 20;
    localparam int BEATS_PER_FRAME = 10;
    localparam int HDR_BITS        = 4;
    localparam int PAYLOAD_BITS    = FRAME_BITS - HDR_BITS;

    localparam logic [HDR_BITS-1:0]     DEF_DATA_HDR  = 4'b1010;
    localparam logic [HDR_BITS-1:0]     DEF_IDLE_HDR  = 4'b1100;
    localparam logic [PAYLOAD_BITS-1:0] DEF_IDLE_WORD = 16'hAAAA;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } ttc_state_e;

endpackage

// File: rtl/ttc_tx_encoder_fifo.sv
// Synchronous input FIFO for the TTC encoder; occupancy is tracked by a level counter.
// Head word is read combinationally so a pop and frame load happen on the same edge.
module ttc_tx_fifo
    import ttc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ttc_tx_encoder.sv
// TTC transmit encoder: buffers 16-bit words, wraps them in 20-bit frames and
// shifts each frame out 2 bits per clk160, with idle frames for sync and fill.
module ttc_tx_encoder
    import ttc_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_FRAMES = 16,
    parameter logic [3:0]  DATA_HDR    = DEF_DATA_HDR,
    parameter logic [3:0]  IDLE_HDR    = DEF_IDLE_HDR,
    parameter logic [15:0] IDLE_WORD   = DEF_IDLE_WORD
) (
    input  logic                          clk160,
    input  logic                          rst_n,
    input  logic [15:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          resync,
    output logic [1:0]                    dout,
    output logic                          frame_start,
    output logic                          sync_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int         SCW       = $clog2(SYNC_FRAMES + 2);
    localparam int         BW        = $clog2(BEATS_PER_FRAME);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_FRAME - 1);
    localparam ttc_state_e RST_STATE = (SYNC_FRAMES == 0) ? RUN : SYNC;

    ttc_state_e              r_state, w_state_nxt;
    logic [SCW-1:0]          r_scnt, w_scnt_nxt, w_scnt_cur;
    logic [BW-1:0]           r_beat;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [FRAME_BITS-1:0]   w_frame_nxt;
    logic [1:0]              r_dout;
    logic                    r_frame_start;
    logic                    r_sync_done, w_sync_done_nxt;
    logic                    r_resync_pend;
    logic                    w_resync;
    logic                    w_boundary;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [15:0]             w_head;

    ttc_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk160),
        .rst_n   (rst_n),
        .i_push  (s_valid),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign s_ready     = rst_n & ~w_full;
    assign dout        = r_dout;
    assign frame_start = r_frame_start;
    assign sync_done   = r_sync_done;
    assign w_boundary  = (r_beat == LAST_BEAT);
    assign w_resync    = r_resync_pend | resync;

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_scnt      <= SCW'(SYNC_FRAMES);
            r_sync_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scnt      <= w_scnt_nxt;
            r_sync_done <= w_sync_done_nxt;
        end
    end

    // A resync boundary behaves like the first SYNC boundary after reset
    always_comb begin
        w_state_nxt     = r_state;
        w_scnt_nxt      = r_scnt;
        w_sync_done_nxt = r_sync_done;
        w_pop           = 1'b0;
        w_frame_nxt     = {IDLE_HDR, IDLE_WORD};
        w_scnt_cur      = w_resync ? SCW'(SYNC_FRAMES) : r_scnt;
        if (w_boundary) begin
            if (w_resync || r_state == SYNC) begin
                w_sync_done_nxt = 1'b0;
                if (w_scnt_cur <= SCW'(1)) begin
                    w_state_nxt = RUN;
                    w_scnt_nxt  = '0;
                end else begin
                    w_state_nxt = SYNC;
                    w_scnt_nxt  = w_scnt_cur - 1'b1;
                end
            end else begin
                w_sync_done_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_frame_nxt = {DATA_HDR, w_head};
                end
            end
        end
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            r_beat        <= LAST_BEAT;
            r_shift       <= '0;
            r_dout        <= 2'b00;
            r_frame_start <= 1'b0;
            r_resync_pend <= 1'b0;
        end else if (w_boundary) begin
            r_beat        <= '0;
            r_shift       <= {w_frame_nxt[FRAME_BITS-3:0], 2'b00};
            r_dout        <= w_frame_nxt[FRAME_BITS-1:FRAME_BITS-2];
            r_frame_start <= 1'b1;
            r_resync_pend <= 1'b0;
        end else begin
            r_beat        <= r_beat + 1'b1;
            r_shift       <= {r_shift[FRAME_BITS-3:0], 2'b00};
            r_dout        <= r_shift[FRAME_BITS-1:FRAME_BITS-2];
            r_frame_start <= 1'b0;
            r_resync_pend <= w_resync;
        end
    end

endmodule

// File: tb/tb_ttc_tx_encoder.sv
// Scoreboard bench for ttc_tx_encoder: expected frames are queued as stimulus is
// issued; a monitor reassembles each 10-beat frame from dout and compares.
module tb_ttc_tx_encoder;

    logic        clk160 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        resync = 1'b0;
    logic [1:0]  dout;
    logic        frame_start;
    logic        sync_done;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];

    ttc_tx_encoder #(
        .FIFO_DEPTH  (4),
        .SYNC_FRAMES (2)
    ) dut (
        .clk160      (clk160),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .resync      (resync),
        .dout        (dout),
        .frame_start (frame_start),
        .sync_done   (sync_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk160 = ~clk160;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [20:0] idle_f(input logic sd);
        return {sd, 4'b1100, 16'hAAAA};
    endfunction

    function automatic logic [20:0] data_f(input logic [15:0] w);
        return {1'b1, 4'b1010, w};
    endfunction

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk160);
            n++;
        end while (!frame_start && n < 40);
        if (!frame_start) chk("frame_start_timeout", frame_start, 1);
    endtask

    task automatic push_one(input logic [15:0] w);
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk160);
        s_valid = 1'b0;
    endtask

    // Monitor: beat 0 is marked by frame_start; beat 9 completes the frame
    int          mcnt = 0;
    logic [19:0] acc;
    logic        sd0;
    logic [20:0] e;
    always @(negedge clk160) begin
        if (!rst_n) begin
            mcnt = 0;
        end else if (frame_start) begin
            chk("frame_align", mcnt, 0);
            acc  = {18'b0, dout};
            sd0  = sync_done;
            mcnt = 1;
        end else if (mcnt > 0) begin
            acc = {acc[17:0], dout};
            mcnt++;
            if (mcnt == 10) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", acc, 20'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", acc, e[19:0]);
                    chk("sync_done", sd0, e[20]);
                end
                mcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [15:0] words[6] = '{16'hC0DE, 16'h5A5A, 16'h0F0F, 16'hFFFF, 16'h0000, 16'h8001};

    initial begin
        int sent;
        int first_block;
        int guard;

        // Reset values
        repeat (3) @(negedge clk160);
        chk("rst_dout", dout, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_sync_done", sync_done, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);

        // Sync burst: F1,F2 idle in SYNC; F3 idle in RUN with sync_done
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b1));
        rst_n = 1'b1;
        @(negedge clk160);
        chk("first_frame_start", frame_start, 1);
        wait_fs();
        wait_fs();

        // F3 beat 4: push 1234 into empty FIFO -> F4 data frame
        exp_q.push_back(data_f(16'h1234));
        repeat (4) @(negedge clk160);
        push_one(16'h1234);
        chk("level_after_push", fifo_level, 1);
        wait_fs();
        chk("level_after_pop", fifo_level, 0);

        // F4 beat 0: six words back-to-back -> F5..F10 slots; F5..F8 carry w0..w3
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(data_f(words[i]));
        end
        sent = 0;
        first_block = -1;
        guard = 0;
        while (sent < 6 && guard < 200) begin
            logic xfer;
            s_data  = words[sent];
            s_valid = 1'b1;
            xfer = s_ready;
            if (!xfer && first_block < 0) first_block = sent;
            @(negedge clk160);
            if (xfer) sent++;
            guard++;
        end
        s_valid = 1'b0;
        chk("words_sent", sent, 6);
        chk("accepted_before_full", first_block, 4);

        // Resync at F8 beat 3 with w4,w5 queued: F9,F10 idle, then w4,w5
        wait_fs();
        wait_fs();
        chk("level_two_queued", fifo_level, 2);
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(data_f(words[4]));
        exp_q.push_back(data_f(words[5]));
        repeat (3) @(negedge clk160);
        resync = 1'b1;
        @(negedge clk160);
        resync = 1'b0;
        wait_fs();
        chk("level_sync1", fifo_level, 2);
        wait_fs();
        chk("level_sync2", fifo_level, 2);
        wait_fs();
        chk("level_run1", fifo_level, 1);
        wait_fs();
        chk("level_run2", fifo_level, 0);

        // F12: push w6 at beat 5, resync on the boundary cycle (beat 9)
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(data_f(16'h3C3C));
        repeat (5) @(negedge clk160);
        push_one(16'h3C3C);
        repeat (3) @(negedge clk160);
        resync = 1'b1;
        @(negedge clk160);
        resync = 1'b0;
        chk("boundary_resync_fs", frame_start, 1);
        chk("boundary_resync_nopop", fifo_level, 1);
        wait_fs();
        chk("level_sync_hold", fifo_level, 1);
        wait_fs();
        chk("level_after_w6", fifo_level, 0);

        // F15: queue w7,w8; reset at beat 5 of the w7 frame
        repeat (2) @(negedge clk160);
        push_one(16'h7777);
        push_one(16'h9999);
        wait_fs();
        repeat (5) @(negedge clk160);
        chk("level_before_reset", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_frame_start", frame_start, 0);
        chk("midrst_fifo_level", fifo_level, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_sync_done", sync_done, 0);
        repeat (3) @(negedge clk160);

        // w8 must be gone: only idle frames follow the reset
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b0));
        exp_q.push_back(idle_f(1'b1));
        rst_n = 1'b1;
        @(negedge clk160);
        chk("post_reset_frame_start", frame_start, 1);
        wait_fs();
        wait_fs();
        wait_fs();
        chk("post_reset_level", fifo_level, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
